// File: rtl/regdst_pipe.sv
// Destination-register pipeline for the MIPS core: decodes the D-stage write target,
// carries it through STAGES registers with a Tnew countdown, and resolves stall/forwarding.

module regdst_stage #(
    parameter int ADDR_W = 5,
    parameter int TNEW_W = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              dec,
    input  logic              prev_vld,
    input  logic [ADDR_W-1:0] prev_dst,
    input  logic [TNEW_W-1:0] prev_tnew,
    output logic              vld,
    output logic [ADDR_W-1:0] dst,
    output logic [TNEW_W-1:0] tnew
);
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            vld  <= 1'b0;
            dst  <= '0;
            tnew <= '0;
        end else begin
            vld  <= prev_vld;
            dst  <= prev_dst;
            // Countdown saturates at zero: a produced result stays forwardable.
            tnew <= (dec && prev_tnew != '0) ? prev_tnew - TNEW_W'(1) : prev_tnew;
        end
    end
endmodule

module regdst_hazard #(
    parameter int ADDR_W = 5,
    parameter int TNEW_W = 2,
    parameter int STAGES = 3,
    parameter int SEL_W  = 2
) (
    input  logic [STAGES-1:0]             vld,
    input  logic [STAGES-1:0][ADDR_W-1:0] dst,
    input  logic [STAGES-1:0][TNEW_W-1:0] tnew,
    input  logic [ADDR_W-1:0]             q_a,
    input  logic [TNEW_W-1:0]             q_tuse,
    output logic                          stall,
    output logic [SEL_W-1:0]              sel
);
    // Scan oldest to youngest so the youngest match is the last one assigned.
    always_comb begin
        stall = 1'b0;
        sel   = '0;
        for (int i = STAGES - 1; i >= 0; i--) begin
            if (q_a != '0 && vld[i] && dst[i] == q_a) begin
                stall = (tnew[i] > q_tuse);
                sel   = (tnew[i] == '0) ? SEL_W'(i + 1) : '0;
            end
        end
    end
endmodule

module regdst_pipe #(
    parameter int ADDR_W   = 5,
    parameter int STAGES   = 3,
    parameter int TNEW_W   = 2,
    parameter int LINK_REG = 31,
    localparam int SEL_W   = $clog2(STAGES + 1)
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [3:0]                 d_regdst,
    input  logic [ADDR_W-1:0]          d_rt,
    input  logic [ADDR_W-1:0]          d_rd,
    input  logic [TNEW_W-1:0]          d_tnew,
    input  logic                       stall,
    input  logic                       flush,
    input  logic [ADDR_W-1:0]          q_a1,
    input  logic [ADDR_W-1:0]          q_a2,
    input  logic [TNEW_W-1:0]          q_tuse1,
    input  logic [TNEW_W-1:0]          q_tuse2,
    output logic [STAGES*ADDR_W-1:0]   stage_dst,
    output logic [STAGES*TNEW_W-1:0]   stage_tnew,
    output logic                       stall_req,
    output logic [SEL_W-1:0]           fwd_sel1,
    output logic [SEL_W-1:0]           fwd_sel2
);
    localparam logic [STAGES-1:0] DEC_EN = ~(STAGES'(1));

    logic [ADDR_W-1:0]             dec_dst;
    logic                          bubble;
    logic [STAGES:0]               vld_pipe;
    logic [STAGES-1:0][ADDR_W-1:0] prev_dst;
    logic [STAGES-1:0][TNEW_W-1:0] prev_tnew;
    logic [STAGES-1:0][ADDR_W-1:0] dst_q;
    logic [STAGES-1:0][TNEW_W-1:0] tnew_q;
    logic                          stall1, stall2;

    always_comb begin
        dec_dst = '0;
        case (d_regdst)
            4'b0001: dec_dst = ADDR_W'(LINK_REG);
            4'b0010: dec_dst = d_rt;
            4'b0011: dec_dst = d_rd;
            default: dec_dst = '0;
        endcase
    end

    // A zero destination is a non-write and is stored exactly like a bubble.
    assign bubble       = stall | flush | (dec_dst == '0);
    assign vld_pipe[0]  = ~bubble;
    assign prev_dst[0]  = bubble ? '0 : dec_dst;
    assign prev_tnew[0] = bubble ? '0 : d_tnew;

    for (genvar k = 1; k < STAGES; k++) begin : g_link
        assign prev_dst[k]  = dst_q[k-1];
        assign prev_tnew[k] = tnew_q[k-1];
    end

    regdst_stage #(.ADDR_W(ADDR_W), .TNEW_W(TNEW_W)) u_stage [STAGES-1:0] (
        .clk       (clk),
        .reset     (reset),
        .dec       (DEC_EN),
        .prev_vld  (vld_pipe[STAGES-1:0]),
        .prev_dst  (prev_dst),
        .prev_tnew (prev_tnew),
        .vld       (vld_pipe[STAGES:1]),
        .dst       (dst_q),
        .tnew      (tnew_q)
    );

    regdst_hazard #(.ADDR_W(ADDR_W), .TNEW_W(TNEW_W), .STAGES(STAGES), .SEL_W(SEL_W)) u_hz1 (
        .vld    (vld_pipe[STAGES:1]),
        .dst    (dst_q),
        .tnew   (tnew_q),
        .q_a    (q_a1),
        .q_tuse (q_tuse1),
        .stall  (stall1),
        .sel    (fwd_sel1)
    );

    regdst_hazard #(.ADDR_W(ADDR_W), .TNEW_W(TNEW_W), .STAGES(STAGES), .SEL_W(SEL_W)) u_hz2 (
        .vld    (vld_pipe[STAGES:1]),
        .dst    (dst_q),
        .tnew   (tnew_q),
        .q_a    (q_a2),
        .q_tuse (q_tuse2),
        .stall  (stall2),
        .sel    (fwd_sel2)
    );

    assign stall_req  = stall1 | stall2;
    assign stage_dst  = dst_q;
    assign stage_tnew = tnew_q;
endmodule

// File: tb/tb_regdst_pipe.sv
// Bench for regdst_pipe: directed table, hand-written hazard sequences, and a
// randomized run against an array-based reference model.

module tb_regdst_pipe;
    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  d_regdst;
    logic [4:0]  d_rt, d_rd, q_a1, q_a2;
    logic [1:0]  d_tnew, q_tuse1, q_tuse2;
    logic        stall, flush;
    logic [14:0] stage_dst;
    logic [5:0]  stage_tnew;
    logic        stall_req;
    logic [1:0]  fwd_sel1, fwd_sel2;

    int checks = 0;
    int errors = 0;

    regdst_pipe dut (
        .clk(clk), .reset(reset), .d_regdst(d_regdst), .d_rt(d_rt), .d_rd(d_rd),
        .d_tnew(d_tnew), .stall(stall), .flush(flush), .q_a1(q_a1), .q_a2(q_a2),
        .q_tuse1(q_tuse1), .q_tuse2(q_tuse2), .stage_dst(stage_dst),
        .stage_tnew(stage_tnew), .stall_req(stall_req), .fwd_sel1(fwd_sel1),
        .fwd_sel2(fwd_sel2)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  regdst;
        logic [4:0]  rt, rd;
        logic [1:0]  tnew;
        logic        stall, flush;
        logic [14:0] exp_dst;
        logic [5:0]  exp_tnew;
    } vec_t;

    vec_t tbl[7];

    // Reference model: three stage slots, index 0 = E.
    int m_dst[3];
    int m_tnew[3];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        d_regdst = 4'd0; d_rt = 5'd0; d_rd = 5'd0; d_tnew = 2'd0;
        stall = 1'b0; flush = 1'b0;
        q_a1 = 5'd0; q_a2 = 5'd0; q_tuse1 = 2'd0; q_tuse2 = 2'd0;
    endtask

    task automatic do_reset();
        #2 reset = 1'b0;
        #1 reset = 1'b1;
        for (int i = 0; i < 3; i++) begin m_dst[i] = 0; m_tnew[i] = 0; end
    endtask

    function automatic int decode(input int mode, input int rt, input int rd);
        if (mode == 1) return 31;
        if (mode == 2) return rt;
        if (mode == 3) return rd;
        return 0;
    endfunction

    function automatic void model_edge();
        int nd;
        nd = decode(d_regdst, d_rt, d_rd);
        for (int k = 2; k > 0; k--) begin
            m_dst[k]  = m_dst[k-1];
            m_tnew[k] = (m_tnew[k-1] > 0) ? m_tnew[k-1] - 1 : 0;
        end
        if (stall || flush || nd == 0) begin m_dst[0] = 0; m_tnew[0] = 0; end
        else begin m_dst[0] = nd; m_tnew[0] = d_tnew; end
    endfunction

    // Returns {stall, sel} for one source query.
    function automatic int model_query(input int a, input int tuse);
        if (a == 0) return 0;
        for (int i = 0; i < 3; i++)
            if (m_dst[i] == a)
                return ((m_tnew[i] > tuse) ? 4 : 0) | ((m_tnew[i] == 0) ? i + 1 : 0);
        return 0;
    endfunction

    initial begin
        tbl[0] = '{4'd3, 5'd0,  5'd9, 2'd2, 1'b0, 1'b0, {5'd0,  5'd0,  5'd9},  {2'd0, 2'd0, 2'd2}};
        tbl[1] = '{4'd1, 5'd0,  5'd0, 2'd3, 1'b0, 1'b0, {5'd0,  5'd9,  5'd31}, {2'd0, 2'd1, 2'd3}};
        tbl[2] = '{4'd7, 5'd0,  5'd7, 2'd1, 1'b0, 1'b0, {5'd9,  5'd31, 5'd0},  {2'd0, 2'd2, 2'd0}};
        tbl[3] = '{4'd2, 5'd12, 5'd0, 2'd0, 1'b0, 1'b0, {5'd31, 5'd0,  5'd12}, {2'd1, 2'd0, 2'd0}};
        tbl[4] = '{4'd3, 5'd0,  5'd7, 2'd2, 1'b0, 1'b1, {5'd0,  5'd12, 5'd0},  {2'd0, 2'd0, 2'd0}};
        tbl[5] = '{4'd2, 5'd0,  5'd0, 2'd3, 1'b0, 1'b0, {5'd12, 5'd0,  5'd0},  {2'd0, 2'd0, 2'd0}};
        tbl[6] = '{4'd0, 5'd0,  5'd5, 2'd1, 1'b0, 1'b0, {5'd0,  5'd0,  5'd0},  {2'd0, 2'd0, 2'd0}};

        idle_inputs();
        reset = 1'b0;
        #2;
        chk("reset_dst", stage_dst, 0);
        chk("reset_tnew", stage_tnew, 0);
        chk("reset_stall", stall_req, 0);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #1;

        // Decode / latency table, one edge per record.
        for (int i = 0; i < 7; i++) begin
            d_regdst = tbl[i].regdst; d_rt = tbl[i].rt; d_rd = tbl[i].rd;
            d_tnew = tbl[i].tnew; stall = tbl[i].stall; flush = tbl[i].flush;
            tick();
            chk($sformatf("tbl%0d_dst", i), stage_dst, tbl[i].exp_dst);
            chk($sformatf("tbl%0d_tnew", i), stage_tnew, tbl[i].exp_tnew);
        end

        // Load-use stall resolved by countdown, then forwarded from W.
        idle_inputs(); do_reset();
        d_regdst = 4'd3; d_rd = 5'd8; d_tnew = 2'd2;
        tick();
        d_regdst = 4'd0; q_a1 = 5'd8; q_tuse1 = 2'd0;
        #1;
        chk("lu_stall0", stall_req, 1);
        chk("lu_sel0", fwd_sel1, 0);
        stall = 1'b1; d_regdst = 4'd3; d_rd = 5'd8;
        tick();
        chk("lu_bubble", stage_dst[4:0], 0);
        chk("lu_stall1", stall_req, 1);
        tick();
        chk("lu_stall2", stall_req, 0);
        chk("lu_sel2", fwd_sel1, 3);
        chk("lu_w_dst", stage_dst[14:10], 8);

        // Youngest match wins; register 0 never matches; stall+flush bubble.
        idle_inputs(); do_reset();
        d_regdst = 4'd3; d_rd = 5'd4; d_tnew = 2'd0;
        tick(); tick();
        q_a2 = 5'd4; q_tuse2 = 2'd0;
        #1;
        chk("young_sel2", fwd_sel2, 1);
        chk("young_stall", stall_req, 0);
        stall = 1'b1; flush = 1'b1; d_rd = 5'd6; d_tnew = 2'd1;
        tick();
        chk("sf_s0", stage_dst[4:0], 0);
        chk("sf_s1", stage_dst[9:5], 4);
        chk("sf_s2", stage_dst[14:10], 4);
        q_a1 = 5'd0; q_tuse1 = 2'd0; q_a2 = 5'd0;
        #1;
        chk("zero_sel1", fwd_sel1, 0);
        chk("zero_stall", stall_req, 0);
        stall = 1'b0; flush = 1'b1; d_regdst = 4'd3; d_rd = 5'd7;
        tick();
        chk("flush_s0", stage_dst[4:0], 0);

        // Asynchronous reset in the middle of a cycle.
        idle_inputs();
        d_regdst = 4'd3; d_rd = 5'd5; d_tnew = 2'd3;
        tick();
        q_a1 = 5'd5; q_tuse1 = 2'd0;
        #1;
        chk("mid_pre_stall", stall_req, 1);
        #1 reset = 1'b0;
        #1;
        chk("mid_dst", stage_dst, 0);
        chk("mid_tnew", stage_tnew, 0);
        chk("mid_stall", stall_req, 0);
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin m_dst[i] = 0; m_tnew[i] = 0; end
        idle_inputs();

        // Randomized run against the reference model.
        for (int c = 0; c < 400; c++) begin
            int r1, r2, pd, pt;
            d_regdst = 4'($urandom_range(0, 5));
            d_rt     = 5'($urandom_range(0, 6));
            d_rd     = 5'($urandom_range(0, 6));
            d_tnew   = 2'($urandom);
            stall    = ($urandom_range(0, 3) == 0);
            flush    = ($urandom_range(0, 5) == 0);
            q_a1     = 5'($urandom_range(0, 6));
            q_a2     = 5'($urandom_range(0, 6));
            q_tuse1  = 2'($urandom);
            q_tuse2  = 2'($urandom);
            #1;
            r1 = model_query(q_a1, q_tuse1);
            r2 = model_query(q_a2, q_tuse2);
            chk("rnd_stall", stall_req, ((r1 | r2) >> 2) & 1);
            chk("rnd_sel1", fwd_sel1, r1 & 3);
            chk("rnd_sel2", fwd_sel2, r2 & 3);
            model_edge();
            tick();
            pd = 0; pt = 0;
            for (int k = 0; k < 3; k++) begin
                pd += m_dst[k] << (5 * k);
                pt += m_tnew[k] << (2 * k);
            end
            chk("rnd_dst", stage_dst, pd);
            chk("rnd_tnew", stage_tnew, pt);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/regdst_pipe.md
# regdst_pipe

Parametrised destination-register pipeline for the pipelined MIPS core. It decodes the D-stage destination selector into a register address and carries it through `STAGES` pipeline registers (E, M, W by default) with a per-stage Tnew countdown. Stall and flush are handled inside the block. From the in-flight destinations it produces the stall request and per-operand forwarding selects, replacing the ad-hoc destination muxes and hazard comparisons in the D stage.

## Interface
Parameters:
- `ADDR_W`, 5: register address width.
- `STAGES`, 3: number of tracked stages after D (index 0 = E, 1 = M, 2 = W).
- `TNEW_W`, 2: Tnew/Tuse counter width.
- `LINK_REG`, 31: destination for link-mode writes.

Ports (clock and reset first):
- `clk`  in  1: clock; all state updates on rising edge.
- `reset`  in  1: asynchronous, active-low; clears all stage state immediately.
- `d_regdst`  in  4: destination mode. 0000 = no write; 0001 = `LINK_REG`; 0010 = `d_rt`; 0011 = `d_rd`; other codes = no write.
- `d_rt`, `d_rd`  in  `ADDR_W`: instruction rt/rd fields.
- `d_tnew`  in  `TNEW_W`: cycles after E entry until the result is produced.
- `stall`  in  1: D held; insert bubble into E.
- `flush`  in  1: replace the D instruction entering E with a bubble.
- `q_a1`, `q_a2`  in  `ADDR_W`: D-stage source addresses to check.
- `q_tuse1`, `q_tuse2`  in  `TNEW_W`: cycles until each source is needed.
- `stage_dst`  out  `STAGES*ADDR_W`: packed destination per stage; slice 0 = E.
- `stage_tnew`  out  `STAGES*TNEW_W`: packed remaining Tnew per stage.
- `stall_req`  out  1: hazard detected; D must stall.
- `fwd_sel1`, `fwd_sel2`  out  `$clog2(STAGES+1)`: 0 = register file; k = forward from stage k-1.

## Operation
- Decode (combinational): the destination is selected by `d_regdst`. A decoded destination of 0 means no write; the entry is stored with dst=0 and tnew=0.
- Stage 0 update, when not in reset:
  - If `stall` or `flush` is 1: stage 0 loads a bubble (dst=0, tnew=0).
  - Otherwise: stage 0 loads the decoded dst and `d_tnew`.
  - Simultaneous `stall` and `flush` also load a bubble.
- Stage k>0 update, every cycle regardless of `stall`: stage k loads stage k-1 with tnew decremented, saturating at 0.
- The entry in the last stage is discarded on the next edge.
- Hazard search, per query q:
  - If q_a=0: no match, sel=0, no stall contribution.
  - Otherwise, the youngest stage i (lowest index) with dst==q_a is the match. Older matches are ignored.
  - If match tnew > q_tuse: `stall_req`=1.
  - If match tnew == 0: sel = i+1. Otherwise sel = 0.
  - No match: sel = 0.
  - `stall_req` is the OR of both queries.
- `stall_req` is combinational. The core feeds it back as `stall`. There is no internal loop: `stall` affects only the next register state.

## Timing
- Reset (asynchronous assert, release on any edge): all `stage_dst`=0 and all `stage_tnew`=0. Consequently `stall_req`=0, `fwd_sel1`=0, `fwd_sel2`=0.
- Reset mid-operation discards all in-flight entries within the same cycle; no pending hazard survives.
- Latency: a decoded dst appears on stage-0 outputs one edge after capture. It appears on stage k after k+1 edges, provided no bubble replaced it at capture.
- `stage_tnew` of an entry n edges after E entry = max(`d_tnew` − n + 1, 0) when n ≥ 1.
- Outputs `stall_req` and `fwd_sel*` respond in the same cycle as changes to `q_*` or stage state. There are no registered hazard outputs.
- Stall duration self-limits: tnew decrements each edge, so `stall_req` clears after at most `d_tnew` − `q_tuse` cycles.

## Test plan
- Reset: drive `reset`=0 mid-stream with dst=5 in E → all stage outputs 0 immediately, `stall_req`=0.
- Mode decode: `d_regdst`=0011, `d_rd`=9, `d_tnew`=2 → after 1 edge stage0 dst=9 tnew=2; after 2 edges stage1 dst=9 tnew=1; after 3 edges stage2 dst=9 tnew=0. `d_regdst`=0001 → dst=31. `d_regdst`=0111 → dst=0.
- Load-use stall: E holds dst=8 tnew=2; `q_a1`=8, `q_tuse1`=0 → `stall_req`=1. With `stall`=1 held, stage0 becomes a bubble each edge. `stall_req` clears when the entry has tnew=0 in stage 2, and `fwd_sel1`=3 in that cycle.
- Youngest-match priority: stage0 dst=4 tnew=0, stage1 dst=4 tnew=0, `q_a2`=4 → `fwd_sel2`=1.
- Register 0 and flush: `q_a1`=0 with stage0 dst=0 → sel=0, no stall. `flush`=1 with `d_rd`=7 → stage0 dst=0 after the edge.
- Stall and flush together with a valid decode → stage0 bubble; M and W continue advancing, confirmed by stage2 receiving the former stage1 value.
